// File: rtl/pipe_stage_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_seq_pkg                                            |
// | Purpose  : Shared types and constants for the staged fp16 search/emit    |
// |            sequencer: FSM state encoding, fp16 constants, default stage  |
// |            indices and small fp16 classification helpers.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pipe_stage_seq_pkg;

  // Run-level sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // fp16 encoding constants
  localparam int          c_FP16_W       = 16;
  localparam logic [15:0] c_FP16_NEG_INF = 16'hFC00;
  localparam logic [15:0] c_FP16_ONE     = 16'h3C00;
  localparam logic [15:0] c_FP16_THRESH  = 16'h3BD7;

  // Default stage map
  localparam int c_NUM_STAGES_DEF   = 8;
  localparam int c_SEARCH_STAGE_DEF = 5;
  localparam int c_EMIT_STAGE_DEF   = 6;
  localparam int c_SENTINEL_DEF     = 4096;

  // Exponent all ones with a non-zero mantissa
  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (&x[14:10]) && (|x[9:0]);
  endfunction

  // +0 and -0 are both zero
  function automatic logic fp16_is_zero(input logic [15:0] x);
    return ~(|x[14:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_seq_if                                             |
// | Purpose  : Input and output beat handshake bundle of pipe_stage_seq.     |
// |            slave = sequencer side, master = producer/consumer side.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pipe_stage_seq_if
  import pipe_stage_seq_pkg::*;
#(
  parameter int LANES = 2,
  parameter int WIDTH = c_FP16_W
);

  // Input beat
  logic                        valid_i;
  logic                        ready_o;
  logic [LANES-1:0][WIDTH-1:0] value_i;
  logic [LANES-1:0][WIDTH-1:0] id_i;

  // Output beat
  logic                        valid_o;
  logic                        ready_i;
  logic [LANES-1:0][WIDTH-1:0] id_o;
  logic [LANES-1:0][WIDTH-1:0] value_o;

  modport slave (
    input  valid_i, value_i, id_i, ready_i,
    output ready_o, valid_o, id_o, value_o
  );

  modport master (
    output valid_i, value_i, id_i, ready_i,
    input  ready_o, valid_o, id_o, value_o
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_seq_fp16_lt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp16_lt                                                       |
// | Purpose  : Combinational fp16 strict less-than (o_lt = i_a < i_b).       |
// |            Sign-magnitude ordering, -0 equals +0, any NaN gives 0.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fp16_lt
  import pipe_stage_seq_pkg::*;
(
  input  wire logic [c_FP16_W-1:0] i_a,
  input  wire logic [c_FP16_W-1:0] i_b,
  output logic                     o_lt
);

  logic w_any_nan;
  logic w_both_zero;

  assign w_any_nan   = fp16_is_nan(i_a) || fp16_is_nan(i_b);
  assign w_both_zero = fp16_is_zero(i_a) && fp16_is_zero(i_b);

  // Order by sign first, then by magnitude (reversed for negatives)
  always_comb begin
    o_lt = 1'b0;
    if (w_any_nan || w_both_zero) begin
      o_lt = 1'b0;
    end else if (i_a[15] != i_b[15]) begin
      // Differing signs: a is smaller exactly when it is the negative one
      o_lt = i_a[15];
    end else if (!i_a[15]) begin
      o_lt = (i_a[14:0] < i_b[14:0]);
    end else begin
      o_lt = (i_a[14:0] > i_b[14:0]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_seq                                                |
// | Purpose  : Beat-counting stage sequencer. Each accepted beat advances a  |
// |            step counter; the stage is derived from the boundary table.   |
// |            One stage tracks a per-lane running max (and its id), another |
// |            emits the max id when the beat value beats a threshold.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_stage_seq
  import pipe_stage_seq_pkg::*;
#(
  parameter int               LANES        = 2,
  parameter int               WIDTH        = c_FP16_W,
  parameter int               STEP_W       = 16,
  parameter int               NUM_STAGES   = c_NUM_STAGES_DEF,
  parameter int               SEARCH_STAGE = c_SEARCH_STAGE_DEF,
  parameter int               EMIT_STAGE   = c_EMIT_STAGE_DEF,
  parameter int               SENTINEL     = c_SENTINEL_DEF,
  parameter logic [WIDTH-1:0] THRESH       = c_FP16_THRESH
)(
  input  wire logic                                 CLK_i,
  input  wire logic                                 RST_i,
  input  wire logic                                 start_i,
  input  wire logic [NUM_STAGES-2:0][STEP_W-1:0]    boundary_i,
  pipe_stage_seq_if.slave                           pipe_if,
  output logic [$clog2(NUM_STAGES)-1:0]             stage_o,
  output logic                                      mode_o,
  output logic                                      busy_o,
  output logic                                      finished_o
);

  localparam int                 STAGE_W      = $clog2(NUM_STAGES);
  localparam logic [STAGE_W-1:0] c_LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] c_SEARCH     = STAGE_W'(SEARCH_STAGE);
  localparam logic [STAGE_W-1:0] c_EMIT       = STAGE_W'(EMIT_STAGE);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [STEP_W-1:0]           r_step;
  logic [STAGE_W-1:0]          r_stage;
  logic [STAGE_W-1:0]          w_stage_nxt;
  int                          w_cnt;
  logic [LANES-1:0][WIDTH-1:0] r_max;
  logic [LANES-1:0][WIDTH-1:0] r_max_id;
  logic [LANES-1:0][WIDTH-1:0] r_id_o;
  logic [LANES-1:0][WIDTH-1:0] r_value_o;
  logic                        r_valid_o;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_start_run;
  logic                        w_in_search;
  logic                        w_in_emit;
  logic                        w_busy;
  logic                        w_finished;
  logic [LANES-1:0]            w_max_lt_val;
  logic [LANES-1:0]            w_thr_lt_val;

  // Input side only opens in RUN and when the output slot can take a result
  assign w_ready     = (r_state == ST_RUN) && (!r_valid_o || pipe_if.ready_i);
  assign w_accept    = pipe_if.valid_i && w_ready;
  // start_i is only honoured outside RUN
  assign w_start_run = start_i && (r_state != ST_RUN);
  // Stage membership of a beat is judged on the stage before the beat
  assign w_in_search = (r_stage == c_SEARCH);
  assign w_in_emit   = (r_stage == c_EMIT);

  // Per-lane comparators: running max vs beat, threshold vs beat
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp16_lt u_max_lt (
      .i_a  (r_max[l]),
      .i_b  (pipe_if.value_i[l]),
      .o_lt (w_max_lt_val[l])
    );
    fp16_lt u_thr_lt (
      .i_a  (THRESH),
      .i_b  (pipe_if.value_i[l]),
      .o_lt (w_thr_lt_val[l])
    );
  end

  // Stage after this beat: number of boundaries strictly below the old step
  always_comb begin
    w_cnt = 0;
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      if (boundary_i[k] < r_step) begin
        w_cnt = w_cnt + 1;
      end
    end
    w_stage_nxt = (w_cnt > NUM_STAGES - 1) ? c_LAST_STAGE : STAGE_W'(w_cnt);
  end

  // State register
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_finished  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        // The beat that would land in the terminal stage ends the run
        if (w_accept && (w_stage_nxt == c_LAST_STAGE)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_finished = 1'b1;
        if (start_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Step counter and stage; both hold on stall, step saturates
  always_ff @(posedge CLK_i) begin
    if (RST_i || w_start_run) begin
      r_step  <= '0;
      r_stage <= '0;
    end else if (w_accept) begin
      if (r_step != '1) begin
        r_step <= r_step + STEP_W'(1);
      end
      r_stage <= w_stage_nxt;
    end
  end

  // Running max per lane; strict compare keeps the earliest id on ties
  always_ff @(posedge CLK_i) begin
    if (RST_i || w_start_run) begin
      for (int l = 0; l < LANES; l++) begin
        r_max[l]    <= WIDTH'(c_FP16_NEG_INF);
        r_max_id[l] <= '0;
      end
    end else if (w_accept && w_in_search) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_max_lt_val[l]) begin
          r_max[l]    <= pipe_if.value_i[l];
          r_max_id[l] <= pipe_if.id_i[l];
        end
      end
    end
  end

  // Output slot: load on an emit beat, drain on ready_i, hold otherwise
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_value_o <= '0;
    end else if (w_start_run) begin
      r_valid_o <= 1'b0;
    end else if (w_accept && w_in_emit) begin
      r_valid_o <= 1'b1;
      for (int l = 0; l < LANES; l++) begin
        if (w_thr_lt_val[l]) begin
          r_id_o[l]    <= r_max_id[l];
          r_value_o[l] <= pipe_if.value_i[l];
        end else begin
          r_id_o[l]    <= WIDTH'(SENTINEL);
          r_value_o[l] <= WIDTH'(c_FP16_ONE);
        end
      end
    end else if (pipe_if.ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

  assign pipe_if.ready_o = w_ready;
  assign pipe_if.valid_o = r_valid_o;
  assign pipe_if.id_o    = r_id_o;
  assign pipe_if.value_o = r_value_o;
  assign stage_o         = r_stage;
  // Tile mode drops to 0 only while in stage 1
  assign mode_o          = (r_stage != STAGE_W'(1));
  assign busy_o          = w_busy;
  assign finished_o      = w_finished;

endmodule
`default_nettype wire
